// File: rtl/riscv_pc_unit.sv
// Program counter / next-PC unit: boot hold-off, branch/jump resolution, stall and misaligned-target trap.
// Optional branch statistics counters are enabled with `define RISCV_PC_BRANCH_STATS_EN.
module riscv_pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned BOOT_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic        Zero,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ImmExt,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [31:0] PCTarget,
    output logic        Running,
    output logic        Trap,
`ifdef RISCV_PC_BRANCH_STATS_EN
    output logic [31:0] BranchCount,
    output logic [31:0] TakenCount,
`endif
    output logic [31:0] TrapPC
);

    typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;

    // BOOT_CYCLES = 0 behaves like a single boot cycle: leave on the first edge.
    localparam logic [7:0] BOOT_LAST = (BOOT_CYCLES == 0) ? 8'd0 : 8'(BOOT_CYCLES - 1);

    state_t      state;
    logic [7:0]  boot_cnt;
    logic [31:0] next_pc;
    logic        redirect;
    logic        misaligned;

    assign PCPlus4  = PC + 32'd4;
    assign PCTarget = PC + ImmExt;

    always_comb begin
        redirect = 1'b1;
        if (JumpReg)
            next_pc = {ALUResult[31:1], 1'b0};
        else if (Jump || (Branch && Zero))
            next_pc = PCTarget;
        else begin
            next_pc  = PCPlus4;
            redirect = 1'b0;
        end
    end

    assign misaligned = redirect && (next_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= BOOT;
            boot_cnt <= 8'd0;
            PC       <= RESET_VECTOR;
            Running  <= 1'b0;
            Trap     <= 1'b0;
            TrapPC   <= 32'd0;
        end else begin
            case (state)
                BOOT: begin
                    boot_cnt <= boot_cnt + 8'd1;
                    if (boot_cnt == BOOT_LAST) begin
                        state   <= RUN;
                        Running <= 1'b1;
                    end
                end
                RUN: begin
                    if (!Stall) begin
                        if (misaligned) begin
                            // PC stays on the faulting instruction until the trap resolves.
                            TrapPC  <= PC;
                            state   <= TRAP;
                            Running <= 1'b0;
                            Trap    <= 1'b1;
                        end else begin
                            PC <= next_pc;
                        end
                    end
                end
                TRAP: begin
                    if (!Stall) begin
                        PC      <= TRAP_VECTOR;
                        state   <= RUN;
                        Running <= 1'b1;
                        Trap    <= 1'b0;
                    end
                end
                default: begin
                    state   <= BOOT;
                    Running <= 1'b0;
                    Trap    <= 1'b0;
                end
            endcase
        end
    end

`ifdef RISCV_PC_BRANCH_STATS_EN
    // Taken branches count even when the target traps.
    always_ff @(posedge clk) begin
        if (reset) begin
            BranchCount <= 32'd0;
            TakenCount  <= 32'd0;
        end else if (state == RUN && !Stall && Branch) begin
            BranchCount <= BranchCount + 32'd1;
            if (Zero)
                TakenCount <= TakenCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_riscv_pc_unit.sv
// Bench for riscv_pc_unit: directed scenarios plus random traffic checked against a cycle model.
module tb_riscv_pc_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;
    localparam int          BC = 4;

    logic        clk = 1'b0;
    logic        reset, Stall, Branch, Jump, JumpReg, Zero;
    logic [31:0] ALUResult, ImmExt;
    logic [31:0] PC, PCPlus4, PCTarget, TrapPC;
    logic        Running, Trap;
`ifdef RISCV_PC_BRANCH_STATS_EN
    logic [31:0] BranchCount, TakenCount;
`endif

    riscv_pc_unit #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV), .BOOT_CYCLES(BC)) dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Branch(Branch), .Jump(Jump),
        .JumpReg(JumpReg), .Zero(Zero), .ALUResult(ALUResult), .ImmExt(ImmExt),
        .PC(PC), .PCPlus4(PCPlus4), .PCTarget(PCTarget), .Running(Running),
        .Trap(Trap),
`ifdef RISCV_PC_BRANCH_STATS_EN
        .BranchCount(BranchCount), .TakenCount(TakenCount),
`endif
        .TrapPC(TrapPC)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Reference model: boot is a countdown of remaining hold cycles, trap is a flag.
    logic [31:0] m_pc, m_trap_pc, m_bc, m_tc;
    int          m_boot_left;
    bit          m_run, m_trap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RV; m_trap_pc = 32'd0; m_bc = 32'd0; m_tc = 32'd0;
        m_boot_left = (BC == 0) ? 1 : BC;
        m_run = 1'b0; m_trap = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        bit          redir;
        if (reset) model_reset();
        else if (m_boot_left > 0) begin
            m_boot_left--;
            if (m_boot_left == 0) m_run = 1'b1;
        end else if (m_trap) begin
            if (!Stall) begin m_pc = TV; m_trap = 1'b0; m_run = 1'b1; end
        end else if (!Stall) begin
            if (Branch) begin
                m_bc++;
                if (Zero) m_tc++;
            end
            redir = JumpReg || Jump || (Branch && Zero);
            if (JumpReg)    tgt = ALUResult - (ALUResult % 2);
            else if (redir) tgt = m_pc + ImmExt;
            else            tgt = m_pc + 4;
            if (redir && (tgt % 4 != 0)) begin
                m_trap_pc = m_pc; m_trap = 1'b1; m_run = 1'b0;
            end else m_pc = tgt;
        end
    endtask

    // Compare everything mid-cycle, then advance model and DUT across one edge.
    task automatic tick();
        @(negedge clk);
        chk("PC", PC, m_pc);
        chk("PCPlus4", PCPlus4, m_pc + 32'd4);
        chk("PCTarget", PCTarget, m_pc + ImmExt);
        chk("Running", {31'd0, Running}, {31'd0, m_run});
        chk("Trap", {31'd0, Trap}, {31'd0, m_trap});
        chk("TrapPC", TrapPC, m_trap_pc);
`ifdef RISCV_PC_BRANCH_STATS_EN
        chk("BranchCount", BranchCount, m_bc);
        chk("TakenCount", TakenCount, m_tc);
`endif
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit r, input bit s, input bit b, input bit j, input bit jr,
                       input bit z, input logic [31:0] alu, input logic [31:0] imm);
        reset = r; Stall = s; Branch = b; Jump = j; JumpReg = jr; Zero = z;
        ALUResult = alu; ImmExt = imm;
    endtask

    task automatic set_pc(input logic [31:0] v);
        drv(0, 0, 0, 0, 1, 0, v, 32'd0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] alu, imm;
        drv(1, 0, 0, 0, 0, 0, 32'd0, 32'd0);
        @(posedge clk); #1;
        model_reset();
        tick();                               // second reset cycle
        chk("reset_pc", PC, RV);
        chk("reset_trappc", TrapPC, 32'd0);

        // Boot hold-off and sequential fetch
        drv(0, 1, 1, 1, 1, 1, 32'h3, 32'h7);  // ignored during boot
        repeat (3) tick();
        chk("boot_running_low", {31'd0, Running}, 32'd0);
        tick();
        chk("boot_running_high", {31'd0, Running}, 32'd1);
        chk("boot_pc_hold", PC, RV);
        drv(0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
        tick(); chk("seq_pc4", PC, 32'h4);
        tick(); chk("seq_pc8", PC, 32'h8);

        // Branch taken / not taken
        set_pc(32'h40);
        drv(0, 0, 1, 0, 0, 1, 32'd0, 32'hFFFF_FFF0);
        tick(); chk("br_taken", PC, 32'h30);
        set_pc(32'h40);
        drv(0, 0, 1, 0, 0, 0, 32'd0, 32'hFFFF_FFF0);
        tick(); chk("br_not_taken", PC, 32'h44);

        // jalr wins over jal, bit 0 cleared
        set_pc(32'h100);
        drv(0, 0, 0, 1, 1, 0, 32'h0000_2001, 32'h40);
        tick(); chk("jalr_prio", PC, 32'h2000);

        // Misaligned jal trap, extended by stall
        set_pc(32'h80);
        drv(0, 0, 0, 1, 0, 0, 32'd0, 32'h6);
        tick();
        chk("trap_set", {31'd0, Trap}, 32'd1);
        chk("trap_pc", TrapPC, 32'h80);
        drv(0, 1, 0, 1, 0, 0, 32'd0, 32'h6);
        tick(); tick();
        chk("trap_stall_trap", {31'd0, Trap}, 32'd1);
        chk("trap_stall_pc", PC, 32'h80);
        drv(0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
        tick();
        chk("trap_vector", PC, 32'h100);
        chk("trap_clear", {31'd0, Trap}, 32'd0);
        chk("trap_running", {31'd0, Running}, 32'd1);

        // Stall hold, then reset during a taken branch
        set_pc(32'h20);
        drv(0, 1, 1, 1, 0, 1, 32'h44, 32'h10);
        repeat (3) tick();
        chk("stall_hold", PC, 32'h20);
        drv(1, 0, 1, 0, 0, 1, 32'd0, 32'h8);
        tick();
        chk("midreset_pc", PC, RV);
        chk("midreset_run", {31'd0, Running}, 32'd0);
        chk("midreset_trap", {31'd0, Trap}, 32'd0);

`ifdef RISCV_PC_BRANCH_STATS_EN
        drv(0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
        repeat (BC) tick();
        drv(0, 0, 1, 0, 0, 1, 32'd0, 32'h8); tick();
        drv(0, 0, 1, 0, 0, 0, 32'd0, 32'h8); tick();
        drv(0, 1, 1, 0, 0, 1, 32'd0, 32'h8); tick(); tick();
        drv(0, 0, 1, 0, 0, 1, 32'd0, 32'h8); tick();
        drv(0, 0, 1, 0, 1, 0, 32'h10, 32'h8); tick();
        drv(0, 0, 1, 1, 0, 1, 32'd0, 32'h8); tick();
        chk("stats_branch", BranchCount, 32'd5);
        chk("stats_taken", TakenCount, 32'd3);
`endif

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            alu = $urandom;
            imm = $urandom;
            if ($urandom_range(0, 7) != 0) alu[1] = 1'b0;
            if ($urandom_range(0, 7) != 0) imm[1:0] = 2'b00;
            drv($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                1'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                1'($urandom), alu, imm);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/riscv_pc_unit.md
# riscv_pc_unit

Program-counter and next-PC unit for the single-cycle RISC-V core, sitting on the consuming end of the ALU result interface. It holds the architectural PC and reads the ALU's `Zero` flag and `ALUResult` to resolve branches and jumps. The ALU's branch encodings produce `ALUResult == 0` when the branch condition holds, so `Zero = 1` always means "taken". The unit also provides a boot hold-off, stall support, and a misaligned-target trap sequence.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: PC value loaded on reset.
- `TRAP_VECTOR`, default 32'h0000_0100: PC value loaded after a misaligned-target trap.
- `BOOT_CYCLES`, default 4: number of cycles after reset for which the PC is held, range 0–255.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `Stall`, in, 1: hold the PC and FSM (effective in RUN and TRAP).
- `Branch`, in, 1: current instruction is a conditional branch.
- `Jump`, in, 1: current instruction is `jal`.
- `JumpReg`, in, 1: current instruction is `jalr`.
- `Zero`, in, 1: ALU zero flag; 1 means branch condition true.
- `ALUResult`, in, 32: ALU output; this is the `jalr` target (rs1 + imm).
- `ImmExt`, in, 32: sign-extended branch/`jal` offset.
- `PC`, out, 32: current instruction address, registered.
- `PCPlus4`, out, 32: `PC + 4`, combinational, modulo 2^32.
- `PCTarget`, out, 32: `PC + ImmExt`, combinational, modulo 2^32.
- `Running`, out, 1: registered; 1 only in RUN.
- `Trap`, out, 1: registered; 1 only in TRAP.
- `TrapPC`, out, 32: registered; PC of the faulting instruction.

## Operation
- **FSM states:** BOOT, RUN, TRAP. Reset drives the FSM to BOOT.
- **BOOT:**
  - An 8-bit counter counts up from 0.
  - The FSM moves to RUN on the edge where the count equals `BOOT_CYCLES-1`, or on the first edge after reset when `BOOT_CYCLES = 0`.
  - PC is held at `RESET_VECTOR`.
  - All instruction inputs and `Stall` are ignored.
- **RUN, next-PC selection** (priority order):
  1. `JumpReg`: `{ALUResult[31:1],1'b0}`.
  2. `Jump`: `PCTarget`.
  3. `Branch & Zero`: `PCTarget`.
  4. Otherwise: `PCPlus4`.
- **RUN, PC update:** on each edge with `Stall = 0`, `PC` is loaded with the selected next PC. With `Stall = 1`, PC and FSM are unchanged.
- **Misaligned target:**
  - Condition: a redirect is selected (cases 1–3) and `target[1:0] != 0`. After the `jalr` bit-0 clear, only bit 1 can trigger this for `jalr`.
  - On the edge with `Stall = 0`: PC is held, `TrapPC <= PC`, FSM goes to TRAP.
- **TRAP:**
  - `Trap = 1`; all instruction inputs are ignored.
  - On the first edge with `Stall = 0`: `PC <= TRAP_VECTOR`, FSM goes to RUN.
  - `Stall = 1` extends TRAP.
- **Concurrent flags:** simultaneous `Jump`/`JumpReg`/`Branch` resolve by the priority above; no error is raised.
- **Reset mid-operation:** `reset` wins over every other input in every state.
- **Reset values:** `PC = RESET_VECTOR`, `Running = 0`, `Trap = 0`, `TrapPC = 0`, boot counter = 0.

## Timing
- No latency from `Zero`/`ALUResult` to next-PC selection (combinational, same cycle). The PC changes on the following edge.
- After `reset` deasserts, `Running` rises at the edge that ends the last BOOT cycle. `PC` stays at `RESET_VECTOR` through BOOT and through the first RUN cycle.
- Trap sequence from detection edge: one or more TRAP cycles with `PC = faulting PC`, then `PC = TRAP_VECTOR` with `Running = 1`.
- `PCPlus4` and `PCTarget` follow `PC`/`ImmExt` combinationally in every state.

## Configuration
- Macro: `RISCV_PC_BRANCH_STATS_EN`.
- **Defined:** adds outputs `BranchCount`, out, 32 and `TakenCount`, out, 32. Both are registered, reset to 0, and wrap modulo 2^32.
  - `BranchCount` increments on each RUN edge with `Stall = 0` and `Branch = 1`, regardless of `Jump`/`JumpReg`.
  - `TakenCount` increments on the same edges when `Zero = 1`, including branches that trap.
- **Undefined:** the ports and counters are absent; all other behaviour is identical.

## Test plan
- **Boot hold-off:** reset for 2 cycles with `BOOT_CYCLES = 4` → `PC = 0` and `Running = 0` for 4 cycles after release; `Running = 1` on cycle 5. Sequential fetches then give `PC` = 0, 4, 8.
- **Branch taken / not taken:** `PC = 0x40`, `Branch = 1`, `ImmExt = 0xFFFF_FFF0`, `Zero = 1` → next `PC = 0x30`. Same inputs with `Zero = 0` → `PC = 0x44`.
- **jalr target and priority:** `PC = 0x100`, `JumpReg = 1`, `Jump = 1`, `ALUResult = 0x0000_2001` → `PC = 0x2000`, bit 0 cleared, `JumpReg` wins over `Jump`.
- **Misaligned trap under stall:** `PC = 0x80`, `Jump = 1`, `ImmExt = 0x6`, no stall → `Trap = 1` and `TrapPC = 0x80` next cycle. Hold `Stall = 1` for 2 cycles → `Trap` stays 1 and `PC = 0x80`. Release `Stall` → `PC = 0x100`, `Trap = 0`.
- **Stall and mid-run reset:** `Stall = 1` for 3 cycles at `PC = 0x20` → PC unchanged. Assert `reset` during a taken branch → `PC = RESET_VECTOR`, FSM in BOOT, `Trap = 0`.
- **Statistics** (with `RISCV_PC_BRANCH_STATS_EN`): 5 branches of which 3 taken, one of them stalled 2 cycles → `BranchCount = 5`, `TakenCount = 3`.
